// File: rtl/stack_pkg.sv
// Shared types and sizing helpers for the JVM operand stack.
package stack_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_PUSH    = 3'd1,
    OP_POP     = 3'd2,
    OP_POP2    = 3'd3,
    OP_DUP     = 3'd4,
    OP_SWAP    = 3'd5,
    OP_REPLACE = 3'd6
  } stack_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_FILL1 = 2'd2,
    ST_FILL2 = 2'd3
  } stack_state_t;

  // Trigger-edge to done_out-edge latencies in clocks
  localparam int unsigned LAT_SINGLE = 1;
  localparam int unsigned LAT_POP    = 2;
  localparam int unsigned LAT_POP2   = 3;
  localparam int unsigned LAT_FAULT  = 1;

  function automatic int unsigned depth_w(input int unsigned size);
    return $clog2(size + 1);
  endfunction

  function automatic int unsigned ram_aw(input int unsigned size);
    return (size > 3) ? $clog2(size - 2) : 1;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// Spill RAM for entries below NOS: one write port, one synchronous read port.
module stack_ram #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ENTRIES = 14,
  parameter int unsigned AW      = 4
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [ENTRIES];
  logic [WIDTH-1:0] r_rdata;

  // Contents are never reset; the depth counter defines which words are live
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/operand_stack.sv
// JVM operand stack: TOS/NOS held in registers, deeper entries spilled to stack_ram.
module operand_stack
  import stack_pkg::*;
#(
  parameter int unsigned STACKDATA = 32,
  parameter int unsigned STACKSIZE = 16,
  localparam int unsigned DEPTH_W  = depth_w(STACKSIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trigger,
  input  logic [2:0]           op,
  input  logic [STACKDATA-1:0] write_value,
  output logic [STACKDATA-1:0] tos,
  output logic [STACKDATA-1:0] nos,
  output logic [DEPTH_W-1:0]   depth,
  output logic                 busy,
  output logic                 done_out,
  output logic                 error
);

  localparam int unsigned AW = ram_aw(STACKSIZE);

  stack_state_t           r_state;
  stack_op_t              r_op;
  logic [STACKDATA-1:0]   r_wval;
  logic [STACKDATA-1:0]   r_tos;
  logic [STACKDATA-1:0]   r_nos;
  logic [DEPTH_W-1:0]     r_depth;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_error;

  logic                   w_fault;
  logic                   w_we;
  logic [AW-1:0]          w_waddr;
  logic [AW-1:0]          w_raddr;
  logic [STACKDATA-1:0]   w_rdata;

  always_comb begin
    w_fault = 1'b0;
    unique case (r_op)
      OP_PUSH:    w_fault = (r_depth == DEPTH_W'(STACKSIZE));
      OP_DUP:     w_fault = (r_depth == DEPTH_W'(STACKSIZE)) || (r_depth == '0);
      OP_POP:     w_fault = (r_depth == '0);
      OP_POP2,
      OP_SWAP,
      OP_REPLACE: w_fault = (r_depth < DEPTH_W'(2));
      default:    w_fault = 1'b0;
    endcase
  end

  // Spill NOS on push; read address leads the FILL cycle that consumes it by one clock
  always_comb begin
    w_we    = 1'b0;
    w_waddr = AW'(r_depth - DEPTH_W'(2));
    w_raddr = AW'(r_depth - DEPTH_W'(3));
    if (r_state == ST_EXEC && !w_fault &&
        (r_op == OP_PUSH || r_op == OP_DUP) && r_depth >= DEPTH_W'(2)) begin
      w_we = 1'b1;
    end
    if (r_state == ST_FILL1) w_raddr = AW'(r_depth - DEPTH_W'(2));
  end

  stack_ram #(
    .WIDTH   (STACKDATA),
    .ENTRIES (STACKSIZE - 2),
    .AW      (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (r_nos),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_op    <= OP_NOP;
      r_wval  <= '0;
      r_tos   <= '0;
      r_nos   <= '0;
      r_depth <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          // busy still high here means this is the done cycle: drop it, accept nothing
          if (r_busy) begin
            r_busy <= 1'b0;
          end else if (trigger) begin
            r_op    <= stack_op_t'(op);
            r_wval  <= write_value;
            r_busy  <= 1'b1;
            r_error <= 1'b0;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (w_fault) begin
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            unique case (r_op)
              OP_PUSH: begin
                r_tos   <= r_wval;
                r_nos   <= r_tos;
                r_depth <= r_depth + DEPTH_W'(1);
                r_done  <= 1'b1;
                r_state <= ST_IDLE;
              end
              OP_DUP: begin
                r_nos   <= r_tos;
                r_depth <= r_depth + DEPTH_W'(1);
                r_done  <= 1'b1;
                r_state <= ST_IDLE;
              end
              OP_SWAP: begin
                r_tos   <= r_nos;
                r_nos   <= r_tos;
                r_done  <= 1'b1;
                r_state <= ST_IDLE;
              end
              OP_POP: begin
                r_tos   <= r_nos;
                r_depth <= r_depth - DEPTH_W'(1);
                r_state <= ST_FILL1;
              end
              OP_REPLACE: begin
                r_tos   <= r_wval;
                r_depth <= r_depth - DEPTH_W'(1);
                r_state <= ST_FILL1;
              end
              OP_POP2: begin
                r_depth <= r_depth - DEPTH_W'(2);
                r_state <= ST_FILL1;
              end
              default: begin
                r_done  <= 1'b1;
                r_state <= ST_IDLE;
              end
            endcase
          end
        end
        ST_FILL1: begin
          // r_depth is already the post-op count in the FILL states
          if (r_op == OP_POP2) begin
            if (r_depth >= DEPTH_W'(1)) r_tos <= w_rdata;
            r_state <= ST_FILL2;
          end else begin
            if (r_depth >= DEPTH_W'(2)) r_nos <= w_rdata;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_FILL2: begin
          if (r_depth >= DEPTH_W'(2)) r_nos <= w_rdata;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tos      = r_tos;
  assign nos      = r_nos;
  assign depth    = r_depth;
  assign busy     = r_busy;
  assign done_out = r_done;
  assign error    = r_error;

endmodule

// File: tb/tb_operand_stack.sv
// Bench for operand_stack: directed vector table, queue-model random ops, busy/reset corners.
module tb_operand_stack;
  import stack_pkg::*;

  localparam int unsigned SD = 32;
  localparam int unsigned SS = 16;
  localparam int unsigned DW = $clog2(SS + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          trigger = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [SD-1:0] write_value = '0;
  logic [SD-1:0] tos;
  logic [SD-1:0] nos;
  logic [DW-1:0] depth;
  logic          busy;
  logic          done_out;
  logic          error;

  int checks = 0;
  int failures = 0;
  logic [31:0] mq[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] val;
    bit          err;
    int          lat;
    int          dep;
    logic [31:0] tos;
    logic [31:0] nos;
  } vec_t;

  vec_t tbl[16];

  operand_stack #(.STACKDATA(SD), .STACKSIZE(SS)) dut (
    .clk         (clk),
    .rst         (rst),
    .trigger     (trigger),
    .op          (op),
    .write_value (write_value),
    .tos         (tos),
    .nos         (nos),
    .depth       (depth),
    .busy        (busy),
    .done_out    (done_out),
    .error       (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op and count clocks from the accepting edge to done_out (-1 on timeout)
  task automatic do_op(input logic [2:0] o, input logic [31:0] v, output int lat, output logic b0);
    @(negedge clk);
    trigger = 1'b1; op = o; write_value = v;
    @(posedge clk); #1;
    trigger = 1'b0;
    b0 = busy;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done_out && lat < 8);
    if (!done_out) lat = -1;
  endtask

  task automatic finish_op(input string nm);
    @(posedge clk); #1;
    chk({nm, " busy_after"}, 32'(busy), 32'd0);
    chk({nm, " done_after"}, 32'(done_out), 32'd0);
  endtask

  // Reference: stack as a queue, back = top
  task automatic model_op(input logic [2:0] o, input logic [31:0] v, output bit err, output int lat);
    int d;
    logic [31:0] t;
    d = mq.size();
    err = 1'b0;
    lat = int'(LAT_SINGLE);
    case (o)
      3'(OP_PUSH):  if (d == SS) err = 1'b1; else mq.push_back(v);
      3'(OP_DUP):   if (d == SS || d < 1) err = 1'b1; else mq.push_back(mq[d-1]);
      3'(OP_POP):   if (d < 1) err = 1'b1;
                    else begin t = mq.pop_back(); lat = int'(LAT_POP); end
      3'(OP_POP2):  if (d < 2) err = 1'b1;
                    else begin t = mq.pop_back(); t = mq.pop_back(); lat = int'(LAT_POP2); end
      3'(OP_SWAP):  if (d < 2) err = 1'b1;
                    else begin t = mq[d-1]; mq[d-1] = mq[d-2]; mq[d-2] = t; end
      3'(OP_REPLACE): if (d < 2) err = 1'b1;
                    else begin t = mq.pop_back(); t = mq.pop_back(); mq.push_back(v); lat = int'(LAT_POP); end
      default: ;
    endcase
    if (err) lat = int'(LAT_FAULT);
  endtask

  task automatic check_model(input string nm, input int lat, input bit eerr, input int elat);
    chk({nm, " lat"}, 32'(lat), 32'(elat));
    chk({nm, " err"}, 32'(error), 32'(eerr));
    chk({nm, " depth"}, 32'(depth), 32'(mq.size()));
    if (mq.size() >= 1) chk({nm, " tos"}, tos, mq[mq.size()-1]);
    if (mq.size() >= 2) chk({nm, " nos"}, nos, mq[mq.size()-2]);
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] v, input string nm);
    int lat, elat;
    logic b0;
    bit eerr;
    do_op(o, v, lat, b0);
    model_op(o, v, eerr, elat);
    chk({nm, " busy_during"}, 32'(b0), 32'd1);
    check_model(nm, lat, eerr, elat);
    finish_op(nm);
  endtask

  initial begin
    int lat;
    logic b0;
    bit eerr, seen_done;
    int elat;
    logic [31:0] saved;
    logic [2:0] ro;

    tbl[0]  = '{3'(OP_PUSH),    32'hcafe_babe, 1'b0, 1, 1, 32'hcafe_babe, 32'h0};
    tbl[1]  = '{3'(OP_POP),     32'h0,         1'b0, 2, 0, 32'h0,         32'h0};
    tbl[2]  = '{3'(OP_POP),     32'h0,         1'b1, 1, 0, 32'h0,         32'h0};
    tbl[3]  = '{3'(OP_PUSH),    32'hdead_beef, 1'b0, 1, 1, 32'hdead_beef, 32'h0};
    tbl[4]  = '{3'(OP_SWAP),    32'h0,         1'b1, 1, 1, 32'hdead_beef, 32'h0};
    tbl[5]  = '{3'(OP_PUSH),    32'hb105_f00d, 1'b0, 1, 2, 32'hb105_f00d, 32'hdead_beef};
    tbl[6]  = '{3'(OP_SWAP),    32'h0,         1'b0, 1, 2, 32'hdead_beef, 32'hb105_f00d};
    tbl[7]  = '{3'(OP_POP2),    32'h0,         1'b0, 3, 0, 32'h0,         32'h0};
    tbl[8]  = '{3'(OP_PUSH),    32'h1,         1'b0, 1, 1, 32'h1,         32'h0};
    tbl[9]  = '{3'(OP_PUSH),    32'h2,         1'b0, 1, 2, 32'h2,         32'h1};
    tbl[10] = '{3'(OP_PUSH),    32'h3,         1'b0, 1, 3, 32'h3,         32'h2};
    tbl[11] = '{3'(OP_PUSH),    32'h4,         1'b0, 1, 4, 32'h4,         32'h3};
    tbl[12] = '{3'(OP_PUSH),    32'h5,         1'b0, 1, 5, 32'h5,         32'h4};
    tbl[13] = '{3'(OP_POP2),    32'h0,         1'b0, 3, 3, 32'h3,         32'h2};
    tbl[14] = '{3'(OP_REPLACE), 32'h9,         1'b0, 2, 2, 32'h9,         32'h1};
    tbl[15] = '{3'(OP_POP2),    32'h0,         1'b0, 3, 0, 32'h0,         32'h0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset depth", 32'(depth), 32'd0);
    chk("reset tos", tos, 32'h0);
    chk("reset nos", nos, 32'h0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done_out), 32'd0);
    chk("reset error", 32'(error), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      do_op(tbl[i].op, tbl[i].val, lat, b0);
      chk($sformatf("vec%0d lat", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("vec%0d err", i), 32'(error), 32'(tbl[i].err));
      chk($sformatf("vec%0d depth", i), 32'(depth), 32'(tbl[i].dep));
      if (tbl[i].dep >= 1) chk($sformatf("vec%0d tos", i), tos, tbl[i].tos);
      if (tbl[i].dep >= 2) chk($sformatf("vec%0d nos", i), nos, tbl[i].nos);
      finish_op($sformatf("vec%0d", i));
    end
    mq.delete();

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: ro = 3'(OP_PUSH);
        4:          ro = 3'(OP_POP);
        5:          ro = 3'(OP_POP2);
        6:          ro = 3'(OP_DUP);
        7:          ro = 3'(OP_SWAP);
        8:          ro = 3'(OP_REPLACE);
        default:    ro = 3'(OP_NOP);
      endcase
      run(ro, $urandom, $sformatf("rnd%0d op%0d", i, ro));
    end

    while (mq.size() < SS) run(3'(OP_PUSH), $urandom, "fill");
    saved = mq[mq.size()-1];
    run(3'(OP_PUSH), 32'h77, "overflow push");
    chk("overflow tos kept", tos, saved);
    chk("overflow depth", 32'(depth), 32'(SS));
    run(3'(OP_DUP), 32'h0, "overflow dup");

    // PUSH held on trigger throughout a POP2, including its done cycle, must be dropped
    @(negedge clk);
    trigger = 1'b1; op = 3'(OP_POP2); write_value = 32'h0;
    @(posedge clk); #1;
    op = 3'(OP_PUSH); write_value = 32'h5555_aaaa;
    chk("busy_ign busy", 32'(busy), 32'd1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done_out && lat < 8);
    if (!done_out) lat = -1;
    model_op(3'(OP_POP2), 32'h0, eerr, elat);
    check_model("busy_ign pop2", lat, eerr, elat);
    @(posedge clk); #1;
    trigger = 1'b0;
    chk("busy_ign idle", 32'(busy), 32'd0);
    seen_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done_out || busy) seen_done = 1'b1;
    end
    chk("busy_ign no extra op", 32'(seen_done), 32'd0);
    chk("busy_ign depth", 32'(depth), 32'(mq.size()));

    // Reset in the middle of a POP2
    @(negedge clk);
    trigger = 1'b1; op = 3'(OP_POP2);
    @(posedge clk); #1;
    trigger = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst depth", 32'(depth), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done_out), 32'd0);
    chk("midrst tos", tos, 32'h0);
    seen_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done_out) seen_done = 1'b1;
    end
    chk("midrst no done", 32'(seen_done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    mq.delete();
    run(3'(OP_PUSH), 32'h1234_5678, "post reset push");
    run(3'(OP_DUP), 32'h0, "post reset dup");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
